// File: rtl/parallel_to_serial_gearbox_pkg.sv
// Shared helpers for the parallel-to-serial gearbox: beat-count and counter-width derivation.
package parallel_to_serial_gearbox_pkg;

  function automatic int nbeats(input int data_w, input int out_w);
    return data_w / out_w;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parallel_to_serial_gearbox_lane.sv
// Active slot: shift register, per-word order flag and beat counter; load takes priority over shift.
module p2s_shift_lane
  import parallel_to_serial_gearbox_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_msb,
  input  logic              shift,
  output logic [OUT_W-1:0]  beat,
  output logic              last,
  output logic              vld
);

  localparam int NBEATS = nbeats(DATA_W, OUT_W);
  localparam int CNT_W  = cnt_w(NBEATS);

  logic [DATA_W-1:0] r_sh;
  logic              r_msb;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_vld;
  logic [DATA_W-1:0] w_shifted;

  // A single-beat word never shifts, so skip the full-width shift expression.
  if (NBEATS > 1) begin : g_shift
    assign w_shifted = r_msb ? {r_sh[DATA_W-OUT_W-1:0], {OUT_W{1'b0}}}
                             : {{OUT_W{1'b0}}, r_sh[DATA_W-1:OUT_W]};
  end else begin : g_noshift
    assign w_shifted = r_sh;
  end

  assign beat = r_msb ? r_sh[DATA_W-1 -: OUT_W] : r_sh[OUT_W-1:0];
  assign last = r_vld & (r_cnt == CNT_W'(NBEATS - 1));
  assign vld  = r_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh  <= '0;
      r_msb <= 1'b0;
      r_cnt <= '0;
      r_vld <= 1'b0;
    end else if (load) begin
      r_sh  <= load_data;
      r_msb <= load_msb;
      r_cnt <= '0;
      r_vld <= 1'b1;
    end else if (shift) begin
      if (last) begin
        r_cnt <= '0;
        r_vld <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        r_sh  <= w_shifted;
      end
    end
  end

endmodule

// File: rtl/parallel_to_serial_gearbox.sv
// Word-to-beat gearbox: one active word being serialised plus a one-word hold slot,
// so the next word is loaded on the same edge the current word's last beat leaves.
module parallel_to_serial_gearbox
  import parallel_to_serial_gearbox_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p_valid_i,
  input  logic [DATA_W-1:0] p_data_i,
  input  logic              p_msb_first_i,
  output logic              p_ready_o,
  output logic              s_valid_o,
  output logic [OUT_W-1:0]  s_data_o,
  output logic              s_last_o,
  input  logic              s_ready_i,
  output logic              busy_o
);

  if (DATA_W < 1 || OUT_W < 1 || (DATA_W % OUT_W) != 0) begin : g_param_check
    $error("parallel_to_serial_gearbox: DATA_W must be a positive multiple of OUT_W");
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              msb_first;
  } slot_t;

  slot_t r_hold;
  logic  r_hold_vld;
  slot_t w_in;
  slot_t w_load_slot;
  logic  w_accept;
  logic  w_beat;
  logic  w_done;
  logic  w_load;
  logic  w_act_vld;
  logic  w_last;

  assign w_in     = '{data: p_data_i, msb_first: p_msb_first_i};
  assign w_accept = p_valid_i & ~r_hold_vld;
  assign w_beat   = w_act_vld & s_ready_i;
  assign w_done   = w_beat & w_last;

  // The hold slot has priority on completion; accept cannot coincide with it since ready is low.
  assign w_load      = (~w_act_vld & w_accept) | (w_done & (r_hold_vld | w_accept));
  assign w_load_slot = (w_done & r_hold_vld) ? r_hold : w_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_accept & w_act_vld & ~w_done) begin
      r_hold     <= w_in;
      r_hold_vld <= 1'b1;
    end else if (w_done & r_hold_vld) begin
      r_hold_vld <= 1'b0;
    end
  end

  p2s_shift_lane #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_lane (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (w_load),
    .load_data (w_load_slot.data),
    .load_msb  (w_load_slot.msb_first),
    .shift     (w_beat),
    .beat      (s_data_o),
    .last      (w_last),
    .vld       (w_act_vld)
  );

  assign p_ready_o = ~r_hold_vld;
  assign s_valid_o = w_act_vld;
  assign s_last_o  = w_last;
  assign busy_o    = w_act_vld | r_hold_vld;

endmodule

// File: tb/tb_parallel_to_serial_gearbox.sv
// Directed scoreboard bench over four gearbox configurations (16/1, 16/4, 16/8, 8/8).
module tb_parallel_to_serial_gearbox;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        pv0 = 0, pm0 = 0, sr0 = 1, pr0, sv0, sl0, bz0;
  logic [15:0] pd0 = '0;
  logic [0:0]  sd0;
  logic        pv1 = 0, pm1 = 0, sr1 = 1, pr1, sv1, sl1, bz1;
  logic [15:0] pd1 = '0;
  logic [3:0]  sd1;
  logic        pv2 = 0, pm2 = 0, sr2 = 1, pr2, sv2, sl2, bz2;
  logic [15:0] pd2 = '0;
  logic [7:0]  sd2;
  logic        pv3 = 0, pm3 = 0, sr3 = 1, pr3, sv3, sl3, bz3;
  logic [7:0]  pd3 = '0;
  logic [7:0]  sd3;

  parallel_to_serial_gearbox #(.DATA_W(16), .OUT_W(1)) u_b1 (
    .clk(clk), .reset_n(reset_n), .p_valid_i(pv0), .p_data_i(pd0), .p_msb_first_i(pm0),
    .p_ready_o(pr0), .s_valid_o(sv0), .s_data_o(sd0), .s_last_o(sl0), .s_ready_i(sr0), .busy_o(bz0));
  parallel_to_serial_gearbox #(.DATA_W(16), .OUT_W(4)) u_b4 (
    .clk(clk), .reset_n(reset_n), .p_valid_i(pv1), .p_data_i(pd1), .p_msb_first_i(pm1),
    .p_ready_o(pr1), .s_valid_o(sv1), .s_data_o(sd1), .s_last_o(sl1), .s_ready_i(sr1), .busy_o(bz1));
  parallel_to_serial_gearbox #(.DATA_W(16), .OUT_W(8)) u_b8 (
    .clk(clk), .reset_n(reset_n), .p_valid_i(pv2), .p_data_i(pd2), .p_msb_first_i(pm2),
    .p_ready_o(pr2), .s_valid_o(sv2), .s_data_o(sd2), .s_last_o(sl2), .s_ready_i(sr2), .busy_o(bz2));
  parallel_to_serial_gearbox #(.DATA_W(8), .OUT_W(8)) u_w8 (
    .clk(clk), .reset_n(reset_n), .p_valid_i(pv3), .p_data_i(pd3), .p_msb_first_i(pm3),
    .p_ready_o(pr3), .s_valid_o(sv3), .s_data_o(sd3), .s_last_o(sl3), .s_ready_i(sr3), .busy_o(bz3));

  int          checks = 0;
  int          errors = 0;
  logic [16:0] expq [4][$];
  int          hs [4];
  bit          accd [4];
  bit          pst [4];
  logic [15:0] pdat [4];
  logic        plst [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beats come straight from the slicing definition, not from a shift model.
  task automatic push(input int i, input int dw, input int ow, input logic [15:0] w, input logic msb);
    int          nb;
    logic [15:0] mask;
    logic [15:0] b;
    nb   = dw / ow;
    mask = 16'((32'd1 << ow) - 32'd1);
    for (int k = 0; k < nb; k++) begin
      b = msb ? ((w >> (dw - (k + 1) * ow)) & mask) : ((w >> (k * ow)) & mask);
      expq[i].push_back({(k == nb - 1), b});
    end
  endtask

  task automatic mon(input int i, input logic pv, input logic pr, input logic v, input logic r,
                     input logic [15:0] d, input logic l);
    logic [16:0] e;
    accd[i] = pv & pr;
    if (pst[i]) begin
      chk($sformatf("stall_valid%0d", i), 32'(v), 32'd1);
      chk($sformatf("stall_data%0d", i), 32'(d), 32'(pdat[i]));
      chk($sformatf("stall_last%0d", i), 32'(l), 32'(plst[i]));
    end
    pst[i]  = v & ~r;
    pdat[i] = d;
    plst[i] = l;
    if (v & r) begin
      hs[i]++;
      chk($sformatf("sb_nonempty%0d", i), 32'(expq[i].size() != 0), 32'd1);
      if (expq[i].size() != 0) begin
        e = expq[i].pop_front();
        chk($sformatf("beat_data%0d", i), 32'(d), 32'(e[15:0]));
        chk($sformatf("beat_last%0d", i), 32'(l), 32'(e[16]));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon(0, pv0, pr0, sv0, sr0, 16'(sd0), sl0);
    mon(1, pv1, pr1, sv1, sr1, 16'(sd1), sl1);
    mon(2, pv2, pr2, sv2, sr2, 16'(sd2), sl2);
    mon(3, pv3, pr3, sv3, sr3, 16'(sd3), sl3);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int i, input int budget, output int n);
    n = 0;
    while (expq[i].size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("drain%0d", i), 32'(expq[i].size()), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      hs[i] = 0; accd[i] = 0; pst[i] = 0; pdat[i] = '0; plst[i] = 0;
    end

    #2;
    chk("rst_valid", 32'(sv0), 32'd0);
    chk("rst_last", 32'(sl0), 32'd0);
    chk("rst_data", 32'(sd0), 32'd0);
    chk("rst_busy", 32'(bz0), 32'd0);
    chk("rst_ready", 32'(pr0), 32'd1);
    chk("rst_data4", 32'(sd1), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 16/1, LSB-first 0xA5C3
    pd0 = 16'hA5C3; pm0 = 1'b0; pv0 = 1'b1;
    push(0, 16, 1, 16'hA5C3, 1'b0);
    tick();
    chk("t1_acc", 32'(accd[0]), 32'd1);
    pv0 = 1'b0;
    chk("t1_latency", 32'(sv0), 32'd1);
    drain(0, 40, n);
    chk("t1_cycles", 32'(n), 32'd16);
    chk("t1_idle_valid", 32'(sv0), 32'd0);
    chk("t1_idle_busy", 32'(bz0), 32'd0);

    // 16/4, MSB-first 0x1234 then LSB-first 0xABCD back-to-back
    pd1 = 16'h1234; pm1 = 1'b1; pv1 = 1'b1;
    push(1, 16, 4, 16'h1234, 1'b1);
    tick();
    pd1 = 16'hABCD; pm1 = 1'b0;
    push(1, 16, 4, 16'hABCD, 1'b0);
    tick();
    chk("t2_acc2", 32'(accd[1]), 32'd1);
    chk("t2_hold_ready", 32'(pr1), 32'd0);
    chk("t2_hold_busy", 32'(bz1), 32'd1);
    pv1 = 1'b0;
    drain(1, 20, n);
    chk("t2_no_bubble", 32'(n), 32'd7);

    // 16/8, 0x00FF under back-pressure
    sr2 = 1'b1; pd2 = 16'h00FF; pm2 = 1'b0; pv2 = 1'b1;
    push(2, 16, 8, 16'h00FF, 1'b0);
    tick();
    pv2 = 1'b0; sr2 = 1'b0;
    tick();
    tick();
    sr2 = 1'b1;
    tick();
    tick();
    chk("t3_empty", 32'(expq[2].size()), 32'd0);
    chk("t3_handshakes", 32'(hs[2]), 32'd2);
    chk("t3_idle_valid", 32'(sv2), 32'd0);

    // 16/4, three words offered while downstream is stalled
    sr1 = 1'b0; pd1 = 16'h4321; pm1 = 1'b0; pv1 = 1'b1;
    push(1, 16, 4, 16'h4321, 1'b0);
    tick();
    chk("t4_acc1", 32'(accd[1]), 32'd1);
    pd1 = 16'h8765; pm1 = 1'b1;
    push(1, 16, 4, 16'h8765, 1'b1);
    tick();
    chk("t4_acc2", 32'(accd[1]), 32'd1);
    chk("t4_ready_low", 32'(pr1), 32'd0);
    pd1 = 16'hCBA9; pm1 = 1'b0;
    push(1, 16, 4, 16'hCBA9, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_blocked", 32'(accd[1]), 32'd0);
    end
    sr1 = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!accd[1] && n < 10);
    chk("t4_acc3", 32'(accd[1]), 32'd1);
    chk("t4_acc3_cycle", 32'(n), 32'd5);
    pv1 = 1'b0;
    drain(1, 30, n);

    // 16/1, reset after 5 of 16 beats
    pd0 = 16'hF0F0; pm0 = 1'b0; pv0 = 1'b1;
    push(0, 16, 1, 16'hF0F0, 1'b0);
    tick();
    pv0 = 1'b0;
    repeat (5) tick();
    chk("t5_before_busy", 32'(bz0), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(sv0), 32'd0);
    chk("t5_rst_busy", 32'(bz0), 32'd0);
    chk("t5_rst_last", 32'(sl0), 32'd0);
    chk("t5_rst_ready", 32'(pr0), 32'd1);
    expq[0].delete();
    pst[0] = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    pd0 = 16'h0001; pm0 = 1'b0; pv0 = 1'b1;
    push(0, 16, 1, 16'h0001, 1'b0);
    tick();
    pv0 = 1'b0;
    drain(0, 40, n);
    chk("t5_cycles", 32'(n), 32'd16);

    // 8/8, single-beat words back-to-back
    pd3 = 8'h11; pm3 = 1'b0; pv3 = 1'b1;
    push(3, 8, 8, 16'h0011, 1'b0);
    tick();
    chk("t6_latency", 32'(sv3), 32'd1);
    chk("t6_last", 32'(sl3), 32'd1);
    pd3 = 8'h22;
    push(3, 8, 8, 16'h0022, 1'b0);
    tick();
    chk("t6_acc2", 32'(accd[3]), 32'd1);
    pv3 = 1'b0;
    drain(3, 10, n);
    chk("t6_consecutive", 32'(n), 32'd1);
    chk("t6_handshakes", 32'(hs[3]), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
